anita_deadtime_gen: RTL and testbench

Generates the trigger-path dead flag on the 250 MHz domain. The flag is the `dead_i` source feeding the deadtime counter/scaler. The block gates incoming triggers against four conditions: post-trigger holdoff, digitizer buffer occupancy, run disable and an optional PPS veto. It reports the cause of deadness for housekeeping. It sits between the trigger decision logic and the SURF buffer-readout handshake.

---
 rtl/anita_deadtime_pkg.sv | 17 +
 rtl/anita_holdoff_timer.sv | 36 +++
 rtl/anita_deadtime_gen.sv | 135 +++++++++++++
 tb/tb_anita_deadtime_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/anita_deadtime_pkg.sv
// Shared types and constants for the ANITA trigger-path deadtime generator.
package anita_deadtime_pkg;

  typedef enum logic [1:0] {
    ST_LIVE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  localparam int CAUSE_HOLDOFF  = 0;
  localparam int CAUSE_FULL     = 1;
  localparam int CAUSE_DISABLED = 2;
  localparam int CAUSE_PPS      = 3;

  localparam logic [3:0] CAUSE_RESET = 4'b0100;

endpackage

// File: rtl/anita_holdoff_timer.sv
// Loadable down-counter that saturates at zero; busy while nonzero.
// o_busy_next exposes the value busy will take after the coming edge.
module anita_holdoff_timer #(
  parameter int W = 8
) (
  input  logic         clk250_i,
  input  logic         rst_i,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_busy,
  output logic         o_busy_next
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_next;

  // NOTE: every path assigns w_count_next, so no latch is inferred.
  always_comb begin
    if (i_load)
      w_count_next = i_value;
    else if (r_count != '0)
      w_count_next = r_count - 1'b1;
    else
      w_count_next = r_count;
  end

  // NOTE: state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) r_count <= '0;
    else       r_count <= w_count_next;
  end

  assign o_busy      = (r_count != '0);
  assign o_busy_next = (w_count_next != '0);

endmodule

// File: rtl/anita_deadtime_gen.sv
// Trigger-path dead flag generator: holdoff, buffer full, run disable and
// optional PPS veto (enabled by defining DEADTIME_PPS_VETO_EN).
module anita_deadtime_gen
  import anita_deadtime_pkg::*;
#(
  parameter int NBUF      = 4,
  parameter int HOLDOFF_W = 8,
  parameter int PPS_VETO  = 63
) (
  input  logic                      clk250_i,
  input  logic                      rst_i,
  input  logic                      trig_i,
  input  logic                      buf_done_i,
  input  logic [HOLDOFF_W-1:0]      holdoff_i,
  input  logic                      disable_i,
`ifdef DEADTIME_PPS_VETO_EN
  input  logic                      pps_i,
`endif
  output logic                      trig_accept_o,
  output logic                      dead_o,
  output logic [$clog2(NBUF+1)-1:0] occupancy_o,
  output logic [3:0]                dead_cause_o,
  output logic                      err_underflow_o
);

  localparam int OCC_W = $clog2(NBUF + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_next;
  logic             r_accept;
  logic             r_full;
  logic             r_disabled;
  logic             r_dead;
  logic             r_err;

  logic w_accept;
  logic w_underflow;
  logic w_full_next;
  logic w_block_next;
  logic w_hold_busy;
  logic w_hold_next;
  logic w_veto_busy;
  logic w_veto_next;

  assign w_accept = trig_i && !r_dead;

  anita_holdoff_timer #(.W(HOLDOFF_W)) u_holdoff (
    .clk250_i    (clk250_i),
    .rst_i       (rst_i),
    .i_load      (w_accept),
    .i_value     (holdoff_i),
    .o_busy      (w_hold_busy),
    .o_busy_next (w_hold_next)
  );

`ifdef DEADTIME_PPS_VETO_EN
  localparam int VETO_W = $clog2(PPS_VETO + 1);

  // Reloading on every pps_i restarts an active veto window.
  anita_holdoff_timer #(.W(VETO_W)) u_pps_veto (
    .clk250_i    (clk250_i),
    .rst_i       (rst_i),
    .i_load      (pps_i),
    .i_value     (VETO_W'(PPS_VETO)),
    .o_busy      (w_veto_busy),
    .o_busy_next (w_veto_next)
  );
`else
  logic w_unused_pps_veto;
  assign w_unused_pps_veto = ^PPS_VETO;
  assign w_veto_busy       = 1'b0;
  assign w_veto_next       = 1'b0;
`endif

  // An accept coinciding with a release cancels out, even at zero occupancy.
  always_comb begin
    w_occ_next  = r_occ;
    w_underflow = 1'b0;
    if (w_accept && !buf_done_i) begin
      w_occ_next = r_occ + 1'b1;
    end else if (buf_done_i && !w_accept) begin
      if (r_occ == '0) w_underflow = 1'b1;
      else             w_occ_next  = r_occ - 1'b1;
    end
  end

  assign w_full_next  = (w_occ_next >= OCC_W'(NBUF));
  assign w_block_next = w_full_next || disable_i || w_veto_next;

  // A running holdoff keeps ownership of the state until its timer expires.
  always_comb begin
    if (w_block_next)
      w_state_next = (r_state == ST_HOLDOFF && w_hold_next) ? ST_HOLDOFF : ST_BLOCKED;
    else if (w_hold_next)
      w_state_next = ST_HOLDOFF;
    else
      w_state_next = ST_LIVE;
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_BLOCKED;
      r_dead     <= 1'b1;
      r_disabled <= 1'b1;
      r_full     <= 1'b0;
      r_occ      <= '0;
      r_accept   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_dead     <= (w_state_next != ST_LIVE);
      r_disabled <= disable_i;
      r_full     <= w_full_next;
      r_occ      <= w_occ_next;
      r_accept   <= w_accept;
      r_err      <= r_err || w_underflow;
    end
  end

  assign trig_accept_o   = r_accept;
  assign dead_o          = r_dead;
  assign occupancy_o     = r_occ;
  assign err_underflow_o = r_err;

  always_comb begin
    dead_cause_o                 = '0;
    dead_cause_o[CAUSE_HOLDOFF]  = w_hold_busy;
    dead_cause_o[CAUSE_FULL]     = r_full;
    dead_cause_o[CAUSE_DISABLED] = r_disabled;
    dead_cause_o[CAUSE_PPS]      = w_veto_busy;
  end

endmodule

// File: tb/tb_anita_deadtime_gen.sv
// Scoreboard bench for anita_deadtime_gen: a behavioural model predicts each
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_anita_deadtime_gen;

  localparam int NBUF      = 4;
  localparam int HOLDOFF_W = 8;
  localparam int PPS_VETO  = 63;
`ifdef DEADTIME_PPS_VETO_EN
  localparam bit PPS_EN = 1'b1;
`else
  localparam bit PPS_EN = 1'b0;
`endif

  logic                 clk250_i = 1'b0;
  logic                 rst_i    = 1'b1;
  logic                 trig_i   = 1'b0;
  logic                 buf_done_i = 1'b0;
  logic [HOLDOFF_W-1:0] holdoff_i  = '0;
  logic                 disable_i  = 1'b0;
  logic                 pps_i      = 1'b0;
  logic                 trig_accept_o;
  logic                 dead_o;
  logic [2:0]           occupancy_o;
  logic [3:0]           dead_cause_o;
  logic                 err_underflow_o;

  anita_deadtime_gen #(
    .NBUF(NBUF), .HOLDOFF_W(HOLDOFF_W), .PPS_VETO(PPS_VETO)
  ) dut (
    .clk250_i        (clk250_i),
    .rst_i           (rst_i),
    .trig_i          (trig_i),
    .buf_done_i      (buf_done_i),
    .holdoff_i       (holdoff_i),
    .disable_i       (disable_i),
`ifdef DEADTIME_PPS_VETO_EN
    .pps_i           (pps_i),
`endif
    .trig_accept_o   (trig_accept_o),
    .dead_o          (dead_o),
    .occupancy_o     (occupancy_o),
    .dead_cause_o    (dead_cause_o),
    .err_underflow_o (err_underflow_o)
  );

  always #2 clk250_i = ~clk250_i;

  typedef struct {
    bit       dead;
    bit [3:0] cause;
    int       occ;
    bit       acc;
    bit       err;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: remaining holdoff/veto cycles, buffers in use, sampled disable.
  int m_occ, m_hold, m_veto;
  bit m_dis, m_err, m_acc;

  function automatic bit m_dead();
    return (m_hold > 0) || (m_occ >= NBUF) || m_dis || (m_veto > 0);
  endfunction

  function automatic exp_t m_exp();
    exp_t e;
    e.dead  = m_dead();
    e.cause = {m_veto > 0, m_dis, m_occ >= NBUF, m_hold > 0};
    e.occ   = m_occ;
    e.acc   = m_acc;
    e.err   = m_err;
    return e;
  endfunction

  task automatic m_reset();
    m_occ = 0; m_hold = 0; m_veto = 0;
    m_dis = 1'b1; m_err = 1'b0; m_acc = 1'b0;
  endtask

  task automatic m_step();
    bit acc;
    acc = trig_i && !m_dead();
    if (acc && !buf_done_i)      m_occ++;
    else if (buf_done_i && !acc) begin
      if (m_occ == 0) m_err = 1'b1;
      else            m_occ--;
    end
    m_hold = acc ? int'(holdoff_i) : (m_hold > 0 ? m_hold - 1 : 0);
    m_veto = (PPS_EN && pps_i) ? PPS_VETO : (m_veto > 0 ? m_veto - 1 : 0);
    m_dis  = disable_i;
    m_acc  = acc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("dead_o",          32'(dead_o),          32'(e.dead));
    check("dead_cause_o",    32'(dead_cause_o),    32'(e.cause));
    check("occupancy_o",     32'(occupancy_o),     32'(e.occ));
    check("trig_accept_o",   32'(trig_accept_o),   32'(e.acc));
    check("err_underflow_o", 32'(err_underflow_o), 32'(e.err));
  endtask

  always @(negedge clk250_i) begin
    if (mon_en) begin
      if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
      else                   check_all(exp_q.pop_front());
    end
  end

  task automatic cycle(input bit trig, input bit done, input bit dis,
                       input bit pps, input int ho);
    trig_i = trig; buf_done_i = done; disable_i = dis; pps_i = pps;
    holdoff_i = HOLDOFF_W'(ho);
    m_step();
    exp_q.push_back(m_exp());
    @(posedge clk250_i); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    mon_en = 1'b0;
    exp_q.delete();
    trig_i = 1'b0; buf_done_i = 1'b0; disable_i = 1'b0; pps_i = 1'b0;
    rst_i = 1'b1;
    #1;
    m_reset();
    check_all(m_exp());
    repeat (2) @(posedge clk250_i);
    #1;
    rst_i = 1'b0;
    exp_q.push_back(m_exp());
    mon_en = 1'b1;
  endtask

  initial begin
    bit dis_lvl;
    @(posedge clk250_i); #1;
    do_reset();
    idle(3);

    // Holdoff of 5 with a dropped trigger at N+3 and an accept at N+6.
    cycle(1, 0, 0, 0, 5);
    idle(2);
    cycle(1, 0, 0, 0, 5);
    idle(2);
    cycle(1, 0, 0, 0, 0);
    idle(3);

    // Fill every buffer with zero holdoff, then release one.
    for (int i = 0; i < NBUF; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle(1);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < NBUF; i++) cycle(0, 1, 0, 0, 0);
    idle(1);

    // Underflow, then simultaneous trigger and release at zero occupancy.
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 3);
    idle(5);

    // Disable pulse overlapping a holdoff.
    cycle(1, 0, 0, 0, 8);
    idle(2);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    idle(10);
    cycle(0, 0, 1, 0, 0);
    idle(3);

    // PPS veto with a restart ten cycles in; trigger coincident with pps.
    cycle(1, 0, 0, 1, 0);
    idle(9);
    cycle(0, 0, 0, 1, 0);
    idle(70);

    // Reset while holding off with buffers in use.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 20);
    idle(2);
    do_reset();
    idle(3);

    // Randomised traffic with occasional resets.
    dis_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int ho;
      if ($urandom_range(0, 99) < 3) dis_lvl = ~dis_lvl;
      ho = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 4));
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, dis_lvl,
            $urandom_range(0, 199) == 0, ho);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    idle(2);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
